// File: rtl/call_latch_if.sv
// Bus between the elevator controller and the call latch.
// Groups the raw button levels, car state and latched request outputs;
// clk and reset stay plain ports on the latch itself.
interface call_latch_if;
  // Raw button levels, high while held.
  logic [2:0] raw_up;       // [0]=F1 .. [2]=F3
  logic [2:0] raw_down;     // [0]=F2 .. [2]=F4
  logic [3:0] raw_in;       // [0]=F1 .. [3]=F4

  // Car state.
  logic [2:0] position;     // even codes are floors, odd codes are between floors
  logic       open;         // 1 = door open
  logic [1:0] direction;    // 00 stop, 01 up, 10 down, 11 invalid

  // Latched requests.
  logic [2:0] button_up;
  logic [2:0] button_down;
  logic [3:0] button_in;
  logic [3:0] pending_cnt;

  // Controller side: drives buttons and car state, reads the latched calls.
  modport master (
    output raw_up, raw_down, raw_in, position, open, direction,
    input  button_up, button_down, button_in, pending_cnt
  );

  // Latch side.
  modport slave (
    input  raw_up, raw_down, raw_in, position, open, direction,
    output button_up, button_down, button_in, pending_cnt
  );
endinterface

// File: rtl/call_latch.sv
// Elevator call latch for a 4-floor car.
// Latches hall-up, hall-down and car button presses on their rising edge and
// clears them when the car stands open at the requested floor in a direction
// that serves the call.
// Optional feature: define CALL_LATCH_CANCEL_EN to let a re-press of a lit car
// button cancel that car request (hall buttons are never cancelled).
module call_latch (
  input  logic         clk,
  input  logic         reset,
  call_latch_if.slave  bus
);

  // Request registers.
  logic [2:0] up_q, up_d;
  logic [2:0] dn_q, dn_d;
  logic [3:0] in_q, in_d;

  // Previous raw levels for edge detection.
  logic [2:0] prev_up_q, prev_up_d;
  logic [2:0] prev_dn_q, prev_dn_d;
  logic [3:0] prev_in_q, prev_in_d;

  logic [2:0] rise_up, rise_dn;
  logic [3:0] rise_in;

  logic       serve_valid;
  logic [3:0] floor_hot;    // one-hot served floor, [0]=F1
  logic       up_dir_ok;
  logic       dn_dir_ok;
  logic [2:0] clr_up, clr_dn;
  logic [3:0] clr_in;

  // Rising-edge detection against the previous raw levels.
  always_comb begin
    rise_up = bus.raw_up   & ~prev_up_q;
    rise_dn = bus.raw_down & ~prev_dn_q;
    rise_in = bus.raw_in   & ~prev_in_q;
  end

  // Work out which request bits the car serves this cycle.
  always_comb begin
    // NOTE: every signal gets a default before any conditional update, so no
    // path leaves a value unassigned and no latch is inferred.
    floor_hot = 4'b0000;
    // Code 111 has position[0] set, so the odd-code test also rejects it.
    serve_valid = bus.open && !bus.position[0];
    if (serve_valid) begin
      floor_hot = 4'b0001 << bus.position[2:1];
    end
    up_dir_ok = (bus.direction == 2'b00) || (bus.direction == 2'b01);
    dn_dir_ok = (bus.direction == 2'b00) || (bus.direction == 2'b10);

    clr_in = floor_hot;
    // Hall-up exists for F1..F3, hall-down for F2..F4.
    clr_up = up_dir_ok ? floor_hot[2:0] : 3'b000;
    clr_dn = dn_dir_ok ? floor_hot[3:1] : 3'b000;
  end

  // Next request state: set on a rising edge, clear wins over a same-cycle set.
  always_comb begin
    up_d = (up_q | rise_up) & ~clr_up;
    dn_d = (dn_q | rise_dn) & ~clr_dn;
`ifdef CALL_LATCH_CANCEL_EN
    // A new press on an already lit car button toggles it off, unless the
    // car is serving that floor anyway.
    in_d = ((in_q | rise_in) & ~clr_in) & ~(rise_in & in_q);
`else
    in_d = (in_q | rise_in) & ~clr_in;
`endif
    prev_up_d = bus.raw_up;
    prev_dn_d = bus.raw_down;
    prev_in_d = bus.raw_in;
  end

  // Register requests and previous raw levels.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      up_q <= '0;
      dn_q <= '0;
      in_q <= '0;
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
      in_q <= in_d;
    end
    // NOTE: the prev flops are deliberately not cleared by reset; they load
    // the live raw levels so a button held through reset is not seen as a
    // fresh press afterwards.
    prev_up_q <= prev_up_d;
    prev_dn_q <= prev_dn_d;
    prev_in_q <= prev_in_d;
  end

  assign bus.button_up   = up_q;
  assign bus.button_down = dn_q;
  assign bus.button_in   = in_q;
  assign bus.pending_cnt = 4'($countones({up_q, dn_q, in_q}));

endmodule
